// File: rtl/dram_burst_ctrl_pkg.sv
// dram_burst_ctrl_pkg: FSM state encoding and array geometry defaults shared with the array top level
package dram_burst_ctrl_pkg;
  localparam int DRAM_ADDR_W    = 13;
  localparam int DRAM_DATA_W    = 64;
  localparam int DRAM_BURST_LEN = 8;
  typedef enum logic [2:0] {IDLE, WRITE, READ, RD_DRAIN, REFRESH} state_t;
endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running refresh interval timer, pending flag and refresh row pointer
//   in: clk, rst (async), refresh_start / refresh_done from the controller FSM
//   out: refresh_pending (refresh owed), ref_row (row of the most recent refresh)
module dram_refresh_timer import dram_burst_ctrl_pkg::*; #(
  parameter int REFRESH_INTERVAL = 512,
  parameter int ROW_W            = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refresh_start,
  input  logic             refresh_done,
  output logic             refresh_pending,
  output logic [ROW_W-1:0] ref_row
);
  localparam int TW = REFRESH_INTERVAL > 1 ? $clog2(REFRESH_INTERVAL) : 1;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             refresh_pending_q, refresh_pending_d;
  logic             active_q, active_d;
  logic [ROW_W-1:0] ref_row_q, ref_row_d;
  logic             expire, done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q             <= '0;
      refresh_pending_q <= 1'b0;
      active_q          <= 1'b0;
      ref_row_q         <= '0;
    end else begin
      tmr_q             <= tmr_d;
      refresh_pending_q <= refresh_pending_d;
      active_q          <= active_d;
      ref_row_q         <= ref_row_d;
    end
  end
  // An expiry landing on the closing cycle of a refresh re-arms the flag instead of being lost.
  always_comb begin
    expire            = tmr_q == TW'(REFRESH_INTERVAL - 1);
    done              = refresh_done && active_q;
    tmr_d             = expire ? '0 : tmr_q + 1'b1;
    refresh_pending_d = expire || (refresh_pending_q && !done);
    active_d          = refresh_start || (active_q && !done);
    ref_row_d         = done ? ref_row_q + 1'b1 : ref_row_q;
  end
  assign refresh_pending = refresh_pending_q;
  assign ref_row         = ref_row_q;
endmodule

// File: rtl/dram_burst_ctrl.sv
// dram_burst_ctrl: host burst front end for the burst DRAM array with periodic refresh windows
//   host: req_* command handshake, wdata_* write beats, rdata_* read beats, wr_done pulse
//   array: mem_en/mem_we/mem_addr/mem_wdata issue, mem_rdata returns one cycle after a read issue
//   status: ref_row (last refreshed row), busy (not IDLE); rst is asynchronous active-high
module dram_burst_ctrl import dram_burst_ctrl_pkg::*; #(
  parameter int ADDR_W           = DRAM_ADDR_W,
  parameter int DATA_W           = DRAM_DATA_W,
  parameter int BURST_LEN        = DRAM_BURST_LEN,
  parameter int REFRESH_INTERVAL = 512,
  parameter int REFRESH_CYCLES   = 4,
  parameter int ROW_W            = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              wr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ROW_W-1:0]  ref_row,
  output logic              busy
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int CW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     rc_q, rc_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              rdata_last_q, rdata_last_d;
  logic              wr_done_q, wr_done_d;
  logic              refresh_pending, refresh_start, refresh_done, issue, last_beat;
  dram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL), .ROW_W(ROW_W)) u_timer (
    .clk             (clk),
    .rst             (rst),
    .refresh_start   (refresh_start),
    .refresh_done    (refresh_done),
    .refresh_pending (refresh_pending),
    .ref_row         (ref_row)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      base_q        <= '0;
      rc_q          <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      base_q        <= base_d;
      rc_q          <= rc_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_last_q  <= rdata_last_d;
      wr_done_q     <= wr_done_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    base_d        = base_q;
    rc_d          = '0;
    rdata_valid_d = state_q == READ;
    rdata_last_d  = state_q == READ && last_beat;
    wr_done_d     = mem_we && last_beat;
    case (state_q)
      IDLE: begin
        if (refresh_pending) state_d = REFRESH;
        else if (req_valid) begin
          base_d  = req_addr;
          beat_d  = '0;
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        if (issue) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = state_q == WRITE ? IDLE : RD_DRAIN;
        end
      end
      RD_DRAIN: state_d = IDLE;
      REFRESH: begin
        rc_d    = refresh_done ? '0 : rc_q + 1'b1;
        state_d = refresh_done ? IDLE : REFRESH;
      end
      default: state_d = IDLE;
    endcase
  end
  // Address wraps modulo 2^ADDR_W so unaligned bursts near the top roll over to 0.
  always_comb begin
    last_beat     = beat_q == BW'(BURST_LEN - 1);
    issue         = (state_q == WRITE && wdata_valid) || state_q == READ;
    req_ready     = state_q == IDLE && !refresh_pending;
    wdata_ready   = state_q == WRITE;
    mem_en        = issue;
    mem_we        = state_q == WRITE && wdata_valid;
    mem_addr      = issue ? base_q + ADDR_W'(beat_q) : '0;
    mem_wdata     = mem_we ? wdata : '0;
    refresh_start = state_q == IDLE && refresh_pending;
    refresh_done  = state_q == REFRESH && rc_q == CW'(REFRESH_CYCLES - 1);
    busy          = state_q != IDLE;
  end
  assign rdata_valid = rdata_valid_q;
  assign rdata_last  = rdata_last_q;
  assign wr_done     = wr_done_q;
  assign rdata       = mem_rdata;
endmodule

// File: tb/tb_dram_burst_ctrl.sv
// tb_dram_burst_ctrl: directed bursts with a queue scoreboard checked by an independent monitor
module tb_dram_burst_ctrl;
  localparam logic [63:0] INIT = 64'hD000_0000_0000_0000;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, wdata_valid = 1'b0;
  logic [12:0] req_addr = '0;
  logic [63:0] wdata = '0;
  logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, mem_en, mem_we, busy;
  logic [12:0] mem_addr;
  logic [63:0] rdata, mem_wdata, mem_rdata;
  logic [3:0]  ref_row;
  int n_cmp = 0, n_err = 0;
  logic [76:0] exp_w[$];
  logic [12:0] exp_ra[$];
  logic [64:0] exp_rd[$];
  logic [12:0] exp_done[$];
  bit [63:0] arr [8192];
  bit        wrt [8192];
  bit        rd_in, prev_rv, prev_wr;
  logic [12:0] prev_waddr;

  dram_burst_ctrl #(.REFRESH_INTERVAL(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last), .wr_done(wr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ref_row(ref_row), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) begin
    if (mem_we) begin
      arr[mem_addr] <= mem_wdata;
      wrt[mem_addr] <= 1'b1;
    end else mem_rdata <= wrt[mem_addr] ? arr[mem_addr] : INIT | 64'(mem_addr);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rd_in = 0; prev_rv = 0; prev_wr = 0;
    end else begin
      if (mem_en && mem_we) begin
        check("wr_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) check("wr_beat", {mem_addr, mem_wdata}, exp_w.pop_front());
      end else if (mem_en) begin
        check("rd_expected", exp_ra.size() != 0, 1);
        if (exp_ra.size() != 0) check("rd_addr", mem_addr, exp_ra.pop_front());
      end else check("idle_zero", {mem_we, mem_addr, mem_wdata}, 0);
      if (rdata_valid) begin
        check("rd_gap", !rd_in || prev_rv, 1);
        check("rdata_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check("rdata_beat", {rdata_last, rdata}, exp_rd.pop_front());
        rd_in = !rdata_last;
      end
      if (wr_done) begin
        check("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) check("wr_done", {prev_wr, prev_waddr}, {1'b1, exp_done.pop_front()});
      end
      prev_rv = rdata_valid; prev_wr = mem_en && mem_we; prev_waddr = mem_addr;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; req_valid = 0; wdata_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic issue_req(input bit wr, input logic [12:0] a);
    int n = 0;
    req_valid = 1; req_write = wr; req_addr = a;
    @(negedge clk);
    while (!req_ready && n < 64) begin n++; @(negedge clk); end
    check("accept", n < 64, 1);
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic do_write(input logic [12:0] base, input logic [63:0] d0, input bit stall, input int nb);
    int b = 0, g = 0;
    bit t = 1;
    for (int i = 0; i < nb; i++) exp_w.push_back({13'(base + 13'(i)), d0 + 64'(i)});
    if (nb == 8) exp_done.push_back(base + 13'd7);
    issue_req(1, base);
    while (b < nb && g < 64) begin
      wdata_valid = stall ? t : 1'b1;
      wdata = d0 + 64'(b);
      t = !t;
      @(negedge clk);
      if (wdata_valid && wdata_ready) b++;
      g++;
      @(posedge clk); #1;
    end
    check("wr_beats_taken", b, nb);
    wdata_valid = 0;
  endtask

  task automatic push_read(input logic [12:0] base, input bit init, input logic [63:0] d0);
    for (int i = 0; i < 8; i++) begin
      logic [12:0] a;
      a = base + 13'(i);
      exp_ra.push_back(a);
      exp_rd.push_back({i == 7, init ? INIT | 64'(a) : d0 + 64'(i)});
    end
  endtask

  initial begin
    int n;
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_ready", req_ready, 1);
    check("rst_outs", {rdata_valid, rdata_last, wr_done, ref_row, mem_addr}, 0);
    // refresh priority over a waiting request
    do_reset();
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("pre_ready", req_ready, 1);
    check("pre_row", ref_row, 0);
    @(posedge clk); #1;
    push_read(13'h040, 1, 0);
    req_valid = 1; req_write = 0; req_addr = 13'h040;
    n = 0;
    @(negedge clk);
    check("row_before_ref", ref_row, 0);
    while (!req_ready && n < 20) begin n++; @(negedge clk); end
    check("ref_block_cycles", n, 5);
    check("row_after_ref", ref_row, 1);
    @(posedge clk); #1 req_valid = 0;
    repeat (14) @(posedge clk);
    // expiry inside a read burst defers a single refresh to after RD_DRAIN
    do_reset();
    repeat (9) @(posedge clk);
    #1;
    push_read(13'h200, 1, 0);
    issue_req(0, 13'h200);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("drain_idle_busy", busy, 0);
    check("drain_idle_ready", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("refresh_busy", {busy, mem_en}, 2'b10);
    end
    @(negedge clk);
    check("post_ref_state", {busy, req_ready}, 2'b01);
    check("single_refresh", ref_row, 1);
    // write then read back, stalled write, wrap-around read
    @(posedge clk); #1;
    do_write(13'h100, 64'hA0, 0, 8);
    push_read(13'h100, 0, 64'hA0);
    issue_req(0, 13'h100);
    do_write(13'h300, 64'hB0, 1, 8);
    push_read(13'h300, 0, 64'hB0);
    issue_req(0, 13'h300);
    push_read(13'd8190, 1, 0);
    issue_req(0, 13'd8190);
    // reset abandons a write after four beats
    do_write(13'h010, 64'hC0, 0, 4);
    rst = 1;
    #1;
    check("async_busy", busy, 0);
    check("async_mem_en", mem_en, 0);
    check("async_ref_row", ref_row, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (6) @(posedge clk);
    #1;
    n = 0;
    while ((exp_rd.size() != 0 || exp_done.size() != 0) && n < 100) begin n++; @(negedge clk); end
    repeat (4) @(negedge clk);
    check("left_w", exp_w.size(), 0);
    check("left_ra", exp_ra.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_done", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
